sc_posregister_jug1: RTL and testbench

- Player-1 position datapath. It is the responder to the player-1 control state machine.
- Executes clear and shift-selection commands on a one-hot-style position register.
- Returns the left/right edge comparator flags that the state machine uses to gate LEFT/RIGHT moves.
- Also keeps a saturating count of accepted moves and flags rejected moves.

---
 rtl/sc_posregister_jug1_pkg.sv | 13 +
 rtl/sc_posregister_jug1_edgecomparator.sv | 15 +
 rtl/sc_posregister_jug1.sv | 86 ++++++++
 tb/tb_sc_posregister_jug1.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/sc_posregister_jug1_pkg.sv
// Shared encodings and defaults for the player position datapaths and their control FSMs.
package sc_posregister_jug1_pkg;

    localparam logic [1:0] SHIFT_HOLD  = 2'b11;
    localparam logic [1:0] SHIFT_LEFT  = 2'b01;
    localparam logic [1:0] SHIFT_RIGHT = 2'b10;
    localparam logic [1:0] SHIFT_LOAD  = 2'b00;

    localparam int unsigned DEF_DATAWIDTH       = 8;
    localparam logic [7:0]  DEF_INIT_POS        = 8'b0001_1000;
    localparam int unsigned DEF_MOVECOUNT_WIDTH = 8;

endpackage

// File: rtl/sc_posregister_jug1_edgecomparator.sv
// Active-low left/right edge flags for a position register; shared by both players.
module sc_edgecomparator #(
    parameter int unsigned Width = 8
) (
    input  logic [Width-1:0] data_i,
    output logic             izquierda_no,
    output logic             derecha_no
);

    always_comb begin
        izquierda_no = ~data_i[Width-1];
        derecha_no   = ~data_i[0];
    end

endmodule

// File: rtl/sc_posregister_jug1.sv
// Player-1 position register: clear/shift/load commands, edge flags, blocked pulse and
// saturating accepted-move counter.
module sc_posregister_jug1
    import sc_posregister_jug1_pkg::*;
#(
    parameter int unsigned          DATAWIDTH       = DEF_DATAWIDTH,
    parameter logic [DATAWIDTH-1:0] INIT_POS        = DATAWIDTH'(DEF_INIT_POS),
    parameter int unsigned          MOVECOUNT_WIDTH = DEF_MOVECOUNT_WIDTH
) (
    input  logic                       sc_posregister_jug1_CLOCK_50,
    input  logic                       sc_posregister_jug1_RESET_InHigh,
    input  logic                       sc_posregister_jug1_clear_InLow,
    input  logic [1:0]                 sc_posregister_jug1_shiftselection_In,
    input  logic [DATAWIDTH-1:0]       sc_posregister_jug1_data_In,
    output logic [DATAWIDTH-1:0]       sc_posregister_jug1_data_Out,
    output logic                       sc_posregister_jug1_izquierdacomparator_OutLow,
    output logic                       sc_posregister_jug1_derechacomparator_OutLow,
    output logic                       sc_posregister_jug1_blocked_Out,
    output logic [MOVECOUNT_WIDTH-1:0] sc_posregister_jug1_movecount_Out
);

    logic [DATAWIDTH-1:0]       data_d, data_q;
    logic [MOVECOUNT_WIDTH-1:0] count_d, count_q;
    logic                       blocked_d, blocked_q;
    logic                       izq_n, der_n;

    sc_edgecomparator #(
        .Width (DATAWIDTH)
    ) u_edgecomparator (
        .data_i       (data_q),
        .izquierda_no (izq_n),
        .derecha_no   (der_n)
    );

    always_comb begin
        data_d    = data_q;
        count_d   = count_q;
        blocked_d = 1'b0;
        if (!sc_posregister_jug1_clear_InLow) begin
            data_d  = INIT_POS;
            count_d = '0;
        end else begin
            case (sc_posregister_jug1_shiftselection_In)
                SHIFT_LEFT: begin
                    if (!izq_n) begin
                        blocked_d = 1'b1;
                    end else begin
                        data_d = {data_q[DATAWIDTH-2:0], 1'b0};
                        if (count_q != '1) count_d = count_q + 1'b1;
                    end
                end
                SHIFT_RIGHT: begin
                    if (!der_n) begin
                        blocked_d = 1'b1;
                    end else begin
                        data_d = {1'b0, data_q[DATAWIDTH-1:1]};
                        if (count_q != '1) count_d = count_q + 1'b1;
                    end
                end
                SHIFT_LOAD: data_d = sc_posregister_jug1_data_In;
                default:    data_d = data_q;
            endcase
        end
    end

    always_ff @(posedge sc_posregister_jug1_CLOCK_50) begin
        if (sc_posregister_jug1_RESET_InHigh) begin
            data_q    <= '0;
            count_q   <= '0;
            blocked_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            count_q   <= count_d;
            blocked_q <= blocked_d;
        end
    end

    always_comb begin
        sc_posregister_jug1_data_Out                   = data_q;
        sc_posregister_jug1_izquierdacomparator_OutLow = izq_n;
        sc_posregister_jug1_derechacomparator_OutLow   = der_n;
        sc_posregister_jug1_blocked_Out                = blocked_q;
        sc_posregister_jug1_movecount_Out              = count_q;
    end

endmodule

// File: tb/tb_sc_posregister_jug1.sv
// Directed-vector bench: driver queues hand-computed expectations, monitor checks after each edge.
module tb_sc_posregister_jug1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr_n = 1'b1;
    logic [1:0] sel = 2'b11;
    logic [7:0] din = 8'h00;

    logic [7:0] data_o, data2_o;
    logic       izq_o, der_o, blk_o, izq2_o, der2_o, blk2_o;
    logic [7:0] cnt_o;
    logic [1:0] cnt2_o;

    typedef struct {
        int         idx;
        logic [7:0] data;
        logic [7:0] cnt;
        logic       blk;
        logic       izq;
        logic       der;
        logic       chk2;
        logic [1:0] cnt2;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   vec_no   = 0;

    always #10 clk = ~clk;

    sc_posregister_jug1 u_dut (
        .sc_posregister_jug1_CLOCK_50                   (clk),
        .sc_posregister_jug1_RESET_InHigh               (rst),
        .sc_posregister_jug1_clear_InLow                (clr_n),
        .sc_posregister_jug1_shiftselection_In          (sel),
        .sc_posregister_jug1_data_In                    (din),
        .sc_posregister_jug1_data_Out                   (data_o),
        .sc_posregister_jug1_izquierdacomparator_OutLow (izq_o),
        .sc_posregister_jug1_derechacomparator_OutLow   (der_o),
        .sc_posregister_jug1_blocked_Out                (blk_o),
        .sc_posregister_jug1_movecount_Out              (cnt_o)
    );

    // Narrow counter instance shares every input; only its counter is checked.
    sc_posregister_jug1 #(
        .MOVECOUNT_WIDTH (2)
    ) u_sat (
        .sc_posregister_jug1_CLOCK_50                   (clk),
        .sc_posregister_jug1_RESET_InHigh               (rst),
        .sc_posregister_jug1_clear_InLow                (clr_n),
        .sc_posregister_jug1_shiftselection_In          (sel),
        .sc_posregister_jug1_data_In                    (din),
        .sc_posregister_jug1_data_Out                   (data2_o),
        .sc_posregister_jug1_izquierdacomparator_OutLow (izq2_o),
        .sc_posregister_jug1_derechacomparator_OutLow   (der2_o),
        .sc_posregister_jug1_blocked_Out                (blk2_o),
        .sc_posregister_jug1_movecount_Out              (cnt2_o)
    );

    task automatic chk(input string name, input int idx, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, got, exp);
        end
    endtask

    task automatic vec(input logic r, input logic c, input logic [1:0] s, input logic [7:0] d,
                       input logic [7:0] e_data, input logic [7:0] e_cnt, input logic e_blk,
                       input logic e_izq, input logic e_der, input logic e_chk2,
                       input logic [1:0] e_cnt2);
        exp_t e;
        @(negedge clk);
        rst   = r;
        clr_n = c;
        sel   = s;
        din   = d;
        e.idx  = vec_no;
        e.data = e_data;
        e.cnt  = e_cnt;
        e.blk  = e_blk;
        e.izq  = e_izq;
        e.der  = e_der;
        e.chk2 = e_chk2;
        e.cnt2 = e_cnt2;
        sb.push_back(e);
        vec_no++;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("data", e.idx, data_o, e.data);
                chk("movecount", e.idx, cnt_o, e.cnt);
                chk("blocked", e.idx, {7'd0, blk_o}, {7'd0, e.blk});
                chk("izquierda", e.idx, {7'd0, izq_o}, {7'd0, e.izq});
                chk("derecha", e.idx, {7'd0, der_o}, {7'd0, e.der});
                if (e.chk2) chk("movecount_sat", e.idx, {6'd0, cnt2_o}, {6'd0, e.cnt2});
            end
        end
    end

    initial begin : driver
        //   rst  clr  sel    din    data   cnt  blk izq der chk2 cnt2
        vec(1'b1, 1'b1, 2'b01, 8'h00, 8'h00, 8'd0, 0, 1, 1, 1, 2'd0);
        vec(1'b1, 1'b1, 2'b01, 8'h00, 8'h00, 8'd0, 0, 1, 1, 1, 2'd0);
        vec(1'b0, 1'b0, 2'b01, 8'h00, 8'h18, 8'd0, 0, 1, 1, 1, 2'd0);
        vec(1'b0, 1'b1, 2'b01, 8'h00, 8'h30, 8'd1, 0, 1, 1, 0, 2'd0);
        vec(1'b0, 1'b1, 2'b01, 8'h00, 8'h60, 8'd2, 0, 1, 1, 0, 2'd0);
        vec(1'b0, 1'b1, 2'b01, 8'h00, 8'hC0, 8'd3, 0, 0, 1, 0, 2'd0);
        vec(1'b0, 1'b1, 2'b01, 8'h00, 8'hC0, 8'd3, 1, 0, 1, 0, 2'd0);
        vec(1'b0, 1'b1, 2'b01, 8'h00, 8'hC0, 8'd3, 1, 0, 1, 0, 2'd0);
        vec(1'b0, 1'b1, 2'b11, 8'h00, 8'hC0, 8'd3, 0, 0, 1, 0, 2'd0);
        vec(1'b0, 1'b1, 2'b00, 8'h03, 8'h03, 8'd3, 0, 1, 0, 0, 2'd0);
        vec(1'b0, 1'b1, 2'b10, 8'h00, 8'h03, 8'd3, 1, 1, 0, 0, 2'd0);
        vec(1'b0, 1'b1, 2'b01, 8'h00, 8'h06, 8'd4, 0, 1, 1, 0, 2'd0);
        vec(1'b0, 1'b1, 2'b10, 8'h00, 8'h03, 8'd5, 0, 1, 0, 0, 2'd0);
        // both edges set: both directions refused
        vec(1'b0, 1'b1, 2'b00, 8'h81, 8'h81, 8'd5, 0, 0, 0, 0, 2'd0);
        vec(1'b0, 1'b1, 2'b01, 8'h00, 8'h81, 8'd5, 1, 0, 0, 0, 2'd0);
        vec(1'b0, 1'b1, 2'b10, 8'h00, 8'h81, 8'd5, 1, 0, 0, 0, 2'd0);
        // all-zero register: shifts accepted, value stays 0
        vec(1'b0, 1'b1, 2'b00, 8'h00, 8'h00, 8'd5, 0, 1, 1, 0, 2'd0);
        vec(1'b0, 1'b1, 2'b01, 8'h00, 8'h00, 8'd6, 0, 1, 1, 0, 2'd0);
        vec(1'b0, 1'b1, 2'b10, 8'h00, 8'h00, 8'd7, 0, 1, 1, 0, 2'd0);
        // priority: clear over shift, reset over clear
        vec(1'b0, 1'b1, 2'b00, 8'h18, 8'h18, 8'd7, 0, 1, 1, 0, 2'd0);
        vec(1'b0, 1'b0, 2'b01, 8'h00, 8'h18, 8'd0, 0, 1, 1, 1, 2'd0);
        vec(1'b1, 1'b0, 2'b01, 8'h00, 8'h00, 8'd0, 0, 1, 1, 1, 2'd0);
        // saturation on the 2-bit counter
        vec(1'b0, 1'b1, 2'b00, 8'h01, 8'h01, 8'd0, 0, 1, 0, 1, 2'd0);
        vec(1'b0, 1'b1, 2'b01, 8'h00, 8'h02, 8'd1, 0, 1, 1, 1, 2'd1);
        vec(1'b0, 1'b1, 2'b01, 8'h00, 8'h04, 8'd2, 0, 1, 1, 1, 2'd2);
        vec(1'b0, 1'b1, 2'b01, 8'h00, 8'h08, 8'd3, 0, 1, 1, 1, 2'd3);
        vec(1'b0, 1'b1, 2'b01, 8'h00, 8'h10, 8'd4, 0, 1, 1, 1, 2'd3);
        vec(1'b0, 1'b1, 2'b01, 8'h00, 8'h20, 8'd5, 0, 1, 1, 1, 2'd3);
        // clear right after a blocked pulse drops it and the counters
        vec(1'b0, 1'b1, 2'b00, 8'h80, 8'h80, 8'd5, 0, 0, 1, 1, 2'd3);
        vec(1'b0, 1'b1, 2'b01, 8'h00, 8'h80, 8'd5, 1, 0, 1, 1, 2'd3);
        vec(1'b0, 1'b0, 2'b01, 8'h00, 8'h18, 8'd0, 0, 1, 1, 1, 2'd0);
        vec(1'b0, 1'b1, 2'b11, 8'h00, 8'h18, 8'd0, 0, 1, 1, 1, 2'd0);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain actual=%0d pending required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
